axis_block_unpacker: RTL and testbench
======================================

// Module: axis_block_unpacker
// PURPOSE
//  Downstream stage of the 128-bit block FIFO. It pops whole AES blocks from
//  the FIFO read port (tvalid/tready) and serialises each one into
//  DATA_WIDTH/WORD_WIDTH words on an AXI4-Stream master.
//  TLAST marks the final word of a software-programmed block count.
//  Sits between the output FIFO and the AXI DMA S2MM path.
// PARAMETERS
//  DATA_WIDTH  128  width of a FIFO entry (one AES block)
//  WORD_WIDTH  32   AXI-Stream tdata width; DATA_WIDTH/WORD_WIDTH integer, >=2
//  CNT_WIDTH   16   width of the block counter / cfg_blocks
//  MSW_FIRST   1    1: bits [DATA_WIDTH-1 -: WORD_WIDTH] go out first; 0: bits [WORD_WIDTH-1:0] go out first
// PORTS
//  clk            in   1           clock
//  reset          in   1           synchronous, active-high
//  cfg_blocks     in   CNT_WIDTH   number of blocks in the packet
//  cfg_valid      in   1           cfg_blocks valid
//  cfg_ready      out  1           high in IDLE; cfg accepted on cfg_valid&&cfg_ready
//  in_tdata       in   DATA_WIDTH  FIFO read data
//  in_tvalid      in   1           FIFO read tvalid
//  in_tready      out  1           FIFO read tready
//  m_axis_tdata   out  WORD_WIDTH  stream data
//  m_axis_tvalid  out  1           stream valid
//  m_axis_tready  in   1           stream ready
//  m_axis_tlast   out  1           last word of packet
//  busy           out  1           state != IDLE
//  done           out  1           1-cycle pulse after final word handshake
// BEHAVIOUR
//  - Reset: state=IDLE; m_axis_tvalid, m_axis_tlast, done, busy, in_tready = 0;
//    m_axis_tdata = 0; block counter and word counter = 0. cfg_ready = 1.
//  - FSM IDLE -> FETCH -> SEND -> (FETCH | IDLE):
//   IDLE: cfg_ready=1. cfg_valid && cfg_blocks!=0: latch blocks_left=cfg_blocks, go FETCH.
//     cfg_blocks==0 is ignored: stay IDLE, done not pulsed.
//   FETCH: in_tready=1 (combinational, = state==FETCH). on in_tvalid: capture
//     in_tdata into shift reg, word_cnt=0, go SEND.
//   SEND: m_axis_tvalid=1, tdata = current word. on m_axis_tvalid&&m_axis_tready:
//     - if word_cnt<RATIO-1: word_cnt++, advance word.
//     - else if blocks_left==1: go IDLE, done=1 next cycle.
//     - else: blocks_left--, go FETCH.
//  - m_axis_tlast = 1 only when word_cnt==RATIO-1 and blocks_left==1.
//  - AXI rule: once m_axis_tvalid=1, tdata/tlast are held stable until the handshake.
//    tvalid never depends combinationally on tready.
//  - Latency: FIFO handshake at cycle N -> first word valid at N+1. Sustained rate is one
//    block per RATIO+1 cycles (no FETCH/SEND overlap; intentional for timing).
//  - in_tready is never high outside FETCH, so at most one FIFO pop per block.
//  - blocks_left is CNT_WIDTH bits; max packet 2^CNT_WIDTH-1 blocks; never wraps.
//  - in_tvalid low in FETCH: wait indefinitely, m_axis_tvalid=0.
//  - cfg_valid outside IDLE: ignored.
//  - done and cfg_ready are both high in the cycle after the final word, so a new
//    cfg is accepted that cycle.
//  - Reset mid-packet: the in-flight block and the remaining count are discarded.
//    No tlast is emitted; outputs return to reset values the next cycle.
// TESTING
//  1. cfg=1; block 00112233_44556677_8899AABB_CCDDEEFF; tready=1 -> words 00112233,
//     44556677, 8899AABB, CCDDEEFF; tlast on word 4 only; done pulse 1 cycle later.
//  2. cfg=3; 3 blocks queued; tready=1 -> 12 words in 15 cycles; 3 in_tvalid&&in_tready
//     handshakes; tlast only on word 12.
//  3. Scenario 1 with tready pattern 1,0,1,0... -> tdata/tlast stable while stalled;
//     no word duplicated or dropped.
//  4. cfg_blocks=0 with cfg_valid=1 -> cfg_ready stays 1, busy=0, no output, no done.
//  5. reset after word 2 of a 2-block packet -> next cycle tvalid=0, tlast=0, busy=0;
//     fresh cfg=1 then emits a correct 4-word packet.
//  6. MSW_FIRST=0, scenario 1 -> CCDDEEFF, 8899AABB, 44556677, 00112233; in_tvalid held
//     low for 10 cycles in FETCH -> tvalid stays 0, output resumes correctly.

Source files
------------

// File: rtl/axis_block_unpacker_if.sv
// rtl/axis_block_unpacker_if.sv - cfg, FIFO read port and AXI-Stream output bundle of the block unpacker
interface axis_block_unpacker_if #(
  parameter int DATA_WIDTH = 128,
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic [CNT_WIDTH-1:0]  cfg_blocks;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [DATA_WIDTH-1:0] in_tdata;
  logic                  in_tvalid;
  logic                  in_tready;
  logic [WORD_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic                  busy;
  logic                  done;

  // Environment side: supplies cfg, FIFO data and downstream ready
  modport master (
    output cfg_blocks, cfg_valid, in_tdata, in_tvalid, m_axis_tready,
    input  cfg_ready, in_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, done
  );

  // Unpacker side
  modport slave (
    input  cfg_blocks, cfg_valid, in_tdata, in_tvalid, m_axis_tready,
    output cfg_ready, in_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, done
  );
endinterface

// File: rtl/axis_block_unpacker.sv
// rtl/axis_block_unpacker.sv - pops whole blocks from the FIFO and serialises them onto AXI-Stream words
module axis_block_unpacker #(
  parameter int DATA_WIDTH = 128,
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter bit MSW_FIRST  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  axis_block_unpacker_if.slave bus
);
  localparam int RATIO = DATA_WIDTH / WORD_WIDTH;
  localparam int WCW   = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] shreg_d;
  logic [DATA_WIDTH-1:0] shreg_adv;
  logic [WORD_WIDTH-1:0] word_out;
  logic [CNT_WIDTH-1:0]  blocks_left_q;
  logic [WCW-1:0]        word_cnt_q;
  logic                  done_q;
  logic                  last_word;
  logic                  last_block;

  // The outgoing word always sits at one end of the shift register; advancing
  // shifts the next word into that position.
  if (MSW_FIRST) begin : gen_msw
    assign word_out  = shreg_q[DATA_WIDTH-1 -: WORD_WIDTH];
    assign shreg_adv = {shreg_q[DATA_WIDTH-WORD_WIDTH-1:0], {WORD_WIDTH{1'b0}}};
  end else begin : gen_lsw
    assign word_out  = shreg_q[WORD_WIDTH-1:0];
    assign shreg_adv = {{WORD_WIDTH{1'b0}}, shreg_q[DATA_WIDTH-1:WORD_WIDTH]};
  end

  assign last_word  = (word_cnt_q == WCW'(RATIO - 1));
  assign last_block = (blocks_left_q == CNT_WIDTH'(1));

  // All outputs decode registered state only, so tvalid/tdata/tlast never
  // depend on tready within the same cycle.
  assign bus.cfg_ready     = (state_q == IDLE);
  assign bus.in_tready     = (state_q == FETCH);
  assign bus.busy          = (state_q != IDLE);
  assign bus.m_axis_tvalid = (state_q == SEND);
  assign bus.m_axis_tlast  = (state_q == SEND) && last_word && last_block;
  assign bus.m_axis_tdata  = word_out;
  assign bus.done          = done_q;

  // Next shift-register contents: load on FIFO pop, shift on a non-final word handshake
  always_comb begin
    shreg_d = shreg_q;
    if (state_q == FETCH && bus.in_tvalid) begin
      shreg_d = bus.in_tdata;
    end else if (state_q == SEND && bus.m_axis_tready && !last_word) begin
      shreg_d = shreg_adv;
    end
  end

  // Block/word sequencing FSM; a held word keeps its data until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      blocks_left_q <= '0;
      word_cnt_q    <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      shreg_q <= shreg_d;
      case (state_q)
        IDLE: begin
          if (bus.cfg_valid && bus.cfg_blocks != '0) begin
            blocks_left_q <= bus.cfg_blocks;
            state_q       <= FETCH;
          end
        end
        FETCH: begin
          if (bus.in_tvalid) begin
            word_cnt_q <= '0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (bus.m_axis_tready) begin
            if (!last_word) begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end else if (last_block) begin
              blocks_left_q <= '0;
              word_cnt_q    <= '0;
              done_q        <= 1'b1;
              state_q       <= IDLE;
            end else begin
              blocks_left_q <= blocks_left_q - 1'b1;
              state_q       <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_block_unpacker.sv
// tb/tb_axis_block_unpacker.sv - scoreboard bench for the block unpacker (MSW-first and LSW-first instances)
module tb_axis_block_unpacker;
  localparam int DW = 128;
  localparam int WW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [CW-1:0] cfg_blocks_v[2];
  logic          cfg_valid_v[2];
  logic          in_tvalid_v[2];
  logic [DW-1:0] in_tdata_v[2];
  logic          tready_v[2];
  logic          hold_v[2];
  int            tready_mode[2];
  logic [DW-1:0] blk_q[2][$];
  logic [WW:0]   exp_q[2][$];
  int            out_hs[2];
  int            dones[2];
  int            in_log[$];
  int            last_out_cyc;

  logic [1:0]    busy_w, tvalid_w, tlast_w, cfg_ready_w, in_tready_w, done_w;
  logic [WW-1:0] tdata0_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    axis_block_unpacker_if #(.DATA_WIDTH(DW), .WORD_WIDTH(WW), .CNT_WIDTH(CW)) bus ();
    axis_block_unpacker #(
      .DATA_WIDTH(DW), .WORD_WIDTH(WW), .CNT_WIDTH(CW), .MSW_FIRST(g == 0)
    ) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
    );

    assign bus.cfg_blocks    = cfg_blocks_v[g];
    assign bus.cfg_valid     = cfg_valid_v[g];
    assign bus.in_tdata      = in_tdata_v[g];
    assign bus.in_tvalid     = in_tvalid_v[g];
    assign bus.m_axis_tready = tready_v[g];
    assign busy_w[g]         = bus.busy;
    assign tvalid_w[g]       = bus.m_axis_tvalid;
    assign tlast_w[g]        = bus.m_axis_tlast;
    assign cfg_ready_w[g]    = bus.cfg_ready;
    assign in_tready_w[g]    = bus.in_tready;
    assign done_w[g]         = bus.done;
    if (g == 0) begin : gen_tap
      assign tdata0_w = bus.m_axis_tdata;
    end

    // FIFO model and downstream ready pattern
    always begin : drv
      logic take;
      @(negedge clk);
      take = bus.in_tvalid && bus.in_tready && !reset;
      if (take && g == 0) in_log.push_back(cyc);
      @(posedge clk);
      #1;
      if (take && blk_q[g].size() != 0) void'(blk_q[g].pop_front());
      in_tvalid_v[g] = (blk_q[g].size() != 0) && !hold_v[g];
      in_tdata_v[g]  = (blk_q[g].size() != 0) ? blk_q[g][0] : '0;
      case (tready_mode[g])
        0:       tready_v[g] = 1'b1;
        1:       tready_v[g] = ~tready_v[g];
        default: tready_v[g] = 1'b0;
      endcase
    end

    // Output monitor: scoreboard pop, stall stability and done timing
    logic        prev_stall = 1'b0;
    logic        prev_last_hs = 1'b0;
    logic [WW:0] prev_word = '0;
    always @(negedge clk) begin : mon
      logic [WW:0] w;
      logic [WW:0] e;
      w = {bus.m_axis_tlast, bus.m_axis_tdata};
      if (reset) begin
        prev_stall   = 1'b0;
        prev_last_hs = 1'b0;
      end else begin
        if (bus.done || prev_last_hs)
          check($sformatf("done_after_tlast[%0d]", g), bus.done, prev_last_hs);
        if (prev_stall && bus.m_axis_tvalid)
          check($sformatf("stall_stable[%0d]", g), w, prev_word);
        prev_last_hs = 1'b0;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          if (exp_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word[%0d] actual=%0h required=none", g, w);
          end else begin
            e = exp_q[g].pop_front();
            check($sformatf("word[%0d]", g), w, e);
          end
          out_hs[g]++;
          if (g == 0) last_out_cyc = cyc;
          prev_last_hs = bus.m_axis_tlast;
        end
        prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_word  = w;
        if (bus.done) dones[g]++;
      end
    end
  end

  task automatic send_cfg(input int g, input int n);
    @(posedge clk); #1;
    cfg_blocks_v[g] = CW'(n);
    cfg_valid_v[g]  = 1'b1;
    @(posedge clk); #1;
    cfg_valid_v[g]  = 1'b0;
  endtask

  task automatic expect4(input int g, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                         input logic [WW-1:0] w2, input logic [WW-1:0] w3, input logic last);
    exp_q[g].push_back({1'b0, w0});
    exp_q[g].push_back({1'b0, w1});
    exp_q[g].push_back({1'b0, w2});
    exp_q[g].push_back({last, w3});
  endtask

  task automatic wait_drain(input int g, input int budget);
    int n = 0;
    @(negedge clk);
    while ((exp_q[g].size() != 0 || busy_w[g]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout[%0d] actual=%0d required=0 words left", g, exp_q[g].size());
    end
    @(negedge clk);
  endtask

  localparam logic [DW-1:0] B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DW-1:0] B2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [DW-1:0] B3 = 128'hDEADBEEF_CAFEF00D_0BADC0DE_A5A55A5A;

  initial begin
    int d0;
    int base;
    int n;
    for (int g = 0; g < 2; g++) begin
      cfg_blocks_v[g] = '0; cfg_valid_v[g] = 1'b0; in_tvalid_v[g] = 1'b0;
      in_tdata_v[g] = '0; tready_v[g] = 1'b1; hold_v[g] = 1'b0;
      tready_mode[g] = 0; out_hs[g] = 0; dones[g] = 0;
    end
    last_out_cyc = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", tvalid_w, 2'b00);
    check("rst_tlast", tlast_w, 2'b00);
    check("rst_busy", busy_w, 2'b00);
    check("rst_done", done_w, 2'b00);
    check("rst_in_tready", in_tready_w, 2'b00);
    check("rst_cfg_ready", cfg_ready_w, 2'b11);
    check("rst_tdata", tdata0_w, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: single block, MSW first
    d0 = dones[0];
    blk_q[0].push_back(B1);
    expect4(0, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 1'b1);
    send_cfg(0, 1);
    wait_drain(0, 100);
    check("t1_done_count", dones[0] - d0, 1);

    // 2: three blocks back to back, cycle budget and pop count
    in_log.delete();
    base = out_hs[0];
    blk_q[0].push_back(B1);
    blk_q[0].push_back(B2);
    blk_q[0].push_back(B3);
    expect4(0, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 1'b0);
    expect4(0, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, 1'b0);
    expect4(0, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE, 32'hA5A55A5A, 1'b1);
    send_cfg(0, 3);
    wait_drain(0, 200);
    check("t2_fifo_pops", in_log.size(), 3);
    check("t2_words", out_hs[0] - base, 12);
    if (in_log.size() != 0) check("t2_span", last_out_cyc - in_log[0], 14);

    // 3: alternating ready, stall stability checked by the monitor
    tready_mode[0] = 1;
    blk_q[0].push_back(B1);
    expect4(0, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 1'b1);
    send_cfg(0, 1);
    wait_drain(0, 200);
    tready_mode[0] = 0;

    // 4: zero-block cfg is ignored
    d0 = dones[0];
    send_cfg(0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_cfg_ready", cfg_ready_w[0], 1'b1);
      check("t4_busy", busy_w[0], 1'b0);
      check("t4_tvalid", tvalid_w[0], 1'b0);
    end
    check("t4_no_done", dones[0] - d0, 0);

    // 5: reset after word 2 of a 2-block packet, then a fresh packet
    base = out_hs[0];
    blk_q[0].push_back(B2);
    blk_q[0].push_back(B3);
    expect4(0, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, 1'b0);
    send_cfg(0, 2);
    n = 0;
    while (out_hs[0] - base < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_reached_word2", out_hs[0] - base, 2);
    reset = 1'b1;
    tready_mode[0] = 2;
    tready_v[0] = 1'b0;
    exp_q[0].delete();
    blk_q[0].delete();
    @(posedge clk);
    @(negedge clk);
    check("t5_tvalid", tvalid_w[0], 1'b0);
    check("t5_tlast", tlast_w[0], 1'b0);
    check("t5_busy", busy_w[0], 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    tready_mode[0] = 0;
    blk_q[0].push_back(B1);
    expect4(0, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 1'b1);
    send_cfg(0, 1);
    wait_drain(0, 100);

    // 6: LSW-first instance, FIFO empty for 10 cycles in FETCH
    d0 = dones[1];
    hold_v[1] = 1'b1;
    blk_q[1].push_back(B1);
    blk_q[1].push_back(B2);
    expect4(1, 32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233, 1'b0);
    expect4(1, 32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567, 1'b1);
    send_cfg(1, 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_tvalid_low", tvalid_w[1], 1'b0);
      check("t6_in_tready", in_tready_w[1], 1'b1);
    end
    hold_v[1] = 1'b0;
    wait_drain(1, 200);
    check("t6_done_count", dones[1] - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
